// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared state encoding and default widths for count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package count_seq_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/count_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer_if
// Description : Control inputs and display-path outputs of count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             ena;
  logic [DIV_W-1:0] cfg_div;
  logic             start;
  logic             stop;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic             tick_out;
  logic             wrap;
  logic             running;
  logic             blank;

  modport master (
    output ena, cfg_div, start, stop, step, dir, limit,
    input  count, tick_out, wrap, running, blank
  );

  modport slave (
    input  ena, cfg_div, start, stop, step, dir, limit,
    output count, tick_out, wrap, running, blank
  );
endinterface
`default_nettype wire

// File: rtl/rise_pulse.sv
`default_nettype none
// ============================================================================
// Module      : rise_pulse
// Description : Registered rising-edge detector; history frozen while en=0.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_pulse (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  input  wire logic d,
  output logic      pulse
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign pulse = en & d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Run/pause/step scheduler driving an up/down modulo digit count.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input wire logic          clk,
  input wire logic          rst_n,
  count_sequencer_if.slave  bus
);

  logic w_start_cmd;
  logic w_stop_cmd;
  logic w_step_cmd;

  rise_pulse u_start (.clk(clk), .rst_n(rst_n), .en(bus.ena), .d(bus.start), .pulse(w_start_cmd));
  rise_pulse u_stop  (.clk(clk), .rst_n(rst_n), .en(bus.ena), .d(bus.stop),  .pulse(w_stop_cmd));
  rise_pulse u_step  (.clk(clk), .rst_n(rst_n), .en(bus.ena), .d(bus.step),  .pulse(w_step_cmd));

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_count,  w_count_nxt;
  logic [DIV_W-1:0] r_presc,  w_presc_nxt;
  logic             r_tick,   w_tick_nxt;
  logic             r_wrap,   w_wrap_nxt;
  logic             w_advance;
  logic [CNT_W-1:0] w_adv_count;
  logic             w_adv_wrap;

  // Value the count would take on an advance; a count above a lowered limit
  // snaps to the limit when counting down.
  always_comb begin
    w_adv_count = r_count;
    w_adv_wrap  = 1'b0;
    if (bus.dir) begin
      if (r_count >= bus.limit) begin
        w_adv_count = '0;
        w_adv_wrap  = 1'b1;
      end else begin
        w_adv_count = r_count + 1'b1;
      end
    end else if (r_count == '0) begin
      w_adv_count = bus.limit;
      w_adv_wrap  = 1'b1;
    end else if (r_count > bus.limit) begin
      w_adv_count = bus.limit;
    end else begin
      w_adv_count = r_count - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_advance   = 1'b0;
    if (bus.ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_stop_cmd) begin
            w_count_nxt = '0;
          end else if (w_start_cmd) begin
            w_state_nxt = ST_RUN;
            w_presc_nxt = '0;
          end else if (w_step_cmd) begin
            w_advance = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_stop_cmd) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_presc >= bus.cfg_div) begin
            w_presc_nxt = '0;
            w_advance   = 1'b1;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (w_stop_cmd) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_presc_nxt = '0;
          end else if (w_start_cmd) begin
            w_state_nxt = ST_RUN;
          end else if (w_step_cmd) begin
            w_advance = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_presc_nxt = '0;
        end
      endcase
    end
    if (w_advance) begin
      w_count_nxt = w_adv_count;
    end
    w_tick_nxt = w_advance;
    w_wrap_nxt = w_advance & w_adv_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.count    = r_count;
  assign bus.tick_out = r_tick;
  assign bus.wrap     = r_wrap;
  assign bus.running  = (r_state == ST_RUN);
  assign bus.blank    = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sequencer
// Description : Directed stimulus with a tick scoreboard for count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;
  import count_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  count_sequencer_if #(.DIV_W(DEF_DIV_W), .CNT_W(DEF_CNT_W)) bus ();

  count_sequencer #(.DIV_W(DEF_DIV_W), .CNT_W(DEF_CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One entry per expected tick: new count, wrap flag, cycles since the
  // previous tick (-1 = not checked).
  typedef struct {
    int cnt;
    int wrp;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   last_tick = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int c, input int w, input int g);
    exp_t e;
    e.cnt = c;
    e.wrp = w;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.wrap) chk("wrap_has_tick", int'(bus.tick_out), 1);
    if (bus.tick_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick_count", int'(bus.count), -1);
      end else begin
        e = exp_q.pop_front();
        chk("tick_count", int'(bus.count), e.cnt);
        chk("tick_wrap", int'(bus.wrap), e.wrp);
        if (e.gap > 0) chk("tick_gap", cyc - last_tick, e.gap);
      end
      last_tick = cyc;
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.cfg_div = 8'd3;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.dir     = 1'b1;
    bus.limit   = 4'd9;
    cycles(3);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_blank", int'(bus.blank), 1);
    chk("rst_tick", int'(bus.tick_out), 0);
    rst_n = 1'b1;
    cycles(1);

    // Up count, period 4, wrap 9 -> 0
    push(1, 0, -1);
    for (int i = 2; i <= 9; i++) push(i, 0, 4);
    push(0, 1, 4);
    push(1, 0, 4);
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    chk("run_running", int'(bus.running), 1);
    chk("run_blank", int'(bus.blank), 0);
    cycles(3);
    chk("first_tick_early", int'(bus.tick_out), 0);
    cycles(1);
    chk("first_tick", int'(bus.tick_out), 1);
    chk("first_count", int'(bus.count), 1);
    cycles(40);

    // Back to IDLE, then down count every cycle with limit 5
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    chk("pause_running", int'(bus.running), 0);
    chk("pause_count", int'(bus.count), 1);
    cycles(1);
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    chk("clear_blank", int'(bus.blank), 1);
    chk("clear_count", int'(bus.count), 0);
    bus.cfg_div = 8'd0;
    bus.dir     = 1'b0;
    bus.limit   = 4'd5;
    push(5, 1, -1);
    push(4, 0, 1); push(3, 0, 1); push(2, 0, 1); push(1, 0, 1); push(0, 0, 1);
    push(5, 1, 1); push(4, 0, 1);
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    chk("down_running", int'(bus.running), 1);
    chk("down_count0", int'(bus.count), 0);
    cycles(8);
    chk("down_count_end", int'(bus.count), 4);

    // Pause/resume with the prescaler retained
    bus.cfg_div = 8'd7;
    bus.dir     = 1'b1;
    bus.limit   = 4'd9;
    push(5, 0, 8);
    cycles(8);
    chk("div7_tick", int'(bus.tick_out), 1);
    chk("div7_count", int'(bus.count), 5);
    cycles(3);
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    chk("hold_running", int'(bus.running), 0);
    cycles(19);
    push(6, 0, 29);
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    chk("resume_running", int'(bus.running), 1);
    cycles(4);
    chk("resume_no_tick", int'(bus.tick_out), 0);
    chk("resume_count_held", int'(bus.count), 5);
    cycles(1);
    chk("resume_tick", int'(bus.tick_out), 1);
    chk("resume_count", int'(bus.count), 6);

    // Steps in PAUSE, including a wrap, then clear and a step in IDLE
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    push(7, 0, 2); push(8, 0, 2); push(9, 0, 2); push(0, 1, 2); push(1, 0, 2);
    repeat (5) begin
      bus.step = 1'b1;
      cycles(1);
      bus.step = 1'b0;
      cycles(1);
    end
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    chk("idle_blank", int'(bus.blank), 1);
    chk("idle_count", int'(bus.count), 0);
    chk("idle_running", int'(bus.running), 0);
    push(1, 0, 3);
    bus.step = 1'b1;
    cycles(1);
    bus.step = 1'b0;
    chk("idle_step_blank", int'(bus.blank), 1);
    chk("idle_step_count", int'(bus.count), 1);

    // Simultaneous commands in RUN: stop wins, nothing advances
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    cycles(1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.step  = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;
    chk("prio_running", int'(bus.running), 0);
    chk("prio_blank", int'(bus.blank), 0);
    chk("prio_count", int'(bus.count), 1);
    chk("prio_tick", int'(bus.tick_out), 0);

    // Step to 8, lower the limit, run with start held high
    cycles(1);
    push(2, 0, 5);
    for (int i = 3; i <= 8; i++) push(i, 0, 2);
    repeat (7) begin
      bus.step = 1'b1;
      cycles(1);
      bus.step = 1'b0;
      cycles(1);
    end
    bus.limit = 4'd3;
    bus.start = 1'b1;
    push(0, 1, 9);
    push(1, 0, 18);
    cycles(1);
    chk("held_running", int'(bus.running), 1);
    cycles(7);
    chk("limit_tick", int'(bus.tick_out), 1);
    chk("limit_wrap", int'(bus.wrap), 1);
    chk("limit_count", int'(bus.count), 0);
    cycles(2);

    // ena low: everything frozen, a stop pulse in the window is ignored
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("ena_low_tick", int'(bus.tick_out), 0);
      chk("ena_low_count", int'(bus.count), 0);
      if (i == 2) bus.stop = 1'b1;
      if (i == 3) bus.stop = 1'b0;
    end
    bus.ena = 1'b1;
    cycles(6);
    chk("ena_back_tick", int'(bus.tick_out), 1);
    chk("ena_back_count", int'(bus.count), 1);
    chk("ena_back_running", int'(bus.running), 1);

    // Stop while start is still held: must stay paused
    bus.stop = 1'b1;
    cycles(1);
    bus.stop = 1'b0;
    cycles(10);
    chk("held_pause_running", int'(bus.running), 0);
    chk("held_pause_count", int'(bus.count), 1);
    cycles(13);
    bus.start = 1'b0;
    chk("held_release_running", int'(bus.running), 0);

    // Synchronous reset mid-RUN at count 6
    bus.limit   = 4'd9;
    bus.cfg_div = 8'd0;
    push(2, 0, 27);
    push(3, 0, 1); push(4, 0, 1); push(5, 0, 1); push(6, 0, 1);
    cycles(1);
    bus.start = 1'b1;
    cycles(1);
    chk("pre_rst_running", int'(bus.running), 1);
    cycles(5);
    chk("pre_rst_count", int'(bus.count), 6);
    rst_n = 1'b0;
    cycles(1);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_running", int'(bus.running), 0);
    chk("mid_rst_blank", int'(bus.blank), 1);
    chk("mid_rst_tick", int'(bus.tick_out), 0);
    rst_n       = 1'b1;
    bus.start   = 1'b0;
    bus.cfg_div = 8'd200;
    cycles(2);
    chk("post_rst_blank", int'(bus.blank), 1);
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
    chk("post_rst_running", int'(bus.running), 1);
    cycles(3);
    chk("post_rst_count", int'(bus.count), 0);
    chk("post_rst_tick", int'(bus.tick_out), 0);

    chk("ticks_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
